branch_resolve_unit: RTL and testbench

Resolution-side partner of the fetch-stage branch predictor. It queues each prediction made at fetch, pops the oldest when the branch resolves in execute, and checks outcome against prediction. On a mispredict it raises a one-cycle flush with the corrected PC and holds a fixed penalty window. Every resolution produces a registered update to the predictor's 2-bit counter and BTB.

---
 rtl/branch_resolve_unit.sv | 167 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: queues fetch-time predictions, checks them at execute and drives
// predictor updates plus mispredict flush/redirect. Optional counters under BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH   = 4,
    parameter int PENALTY = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        push_valid,
    input  logic [31:0] push_pc,
    input  logic        push_pred_taken,
    input  logic [31:0] push_pred_target,
    output logic        push_ready,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        q_empty,
    output logic        resolve_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
`endif
);

    typedef logic [31:0] word_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PEN_W = (PENALTY > 1) ? $clog2(PENALTY) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(PENALTY - 1);

    state_t             state;
    logic [PEN_W-1:0]   pen_cnt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_n, rd_n;
    logic [CNT_W-1:0]   count, count_n;

    word_t pc_mem    [DEPTH];
    word_t tgt_mem   [DEPTH];
    logic  taken_mem [DEPTH];

    logic  push_fire_p0, pop_p0, err_p0, mispred_p0;
    word_t head_pc_p0, head_tgt_p0, correct_pc_p0, upd_tgt_p0;
    logic  head_taken_p0;

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---- p0: resolve-cycle decisions from registered queue state ----
    always_comb begin
        push_fire_p0  = push_valid & push_ready;
        pop_p0        = resolve_valid & ~busy & (count != '0);
        err_p0        = resolve_valid & ~busy & (count == '0);
        head_pc_p0    = pc_mem[rd_ptr];
        head_tgt_p0   = tgt_mem[rd_ptr];
        head_taken_p0 = taken_mem[rd_ptr];
        mispred_p0    = pop_p0 & ((head_taken_p0 != resolve_taken) |
                                  (head_taken_p0 & resolve_taken & (head_tgt_p0 != resolve_target)));
        correct_pc_p0 = resolve_taken ? resolve_target : head_pc_p0 + 32'd4;
        upd_tgt_p0    = resolve_taken ? resolve_target : head_tgt_p0;
    end

    // A mispredict squashes everything in flight, including a same-cycle push.
    always_comb begin
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        count_n = count;
        if (mispred_p0) begin
            wr_n    = '0;
            rd_n    = '0;
            count_n = '0;
        end else begin
            if (push_fire_p0) wr_n = wr_ptr + PTR_W'(1);
            if (pop_p0)       rd_n = rd_ptr + PTR_W'(1);
            count_n = count + CNT_W'(push_fire_p0) - CNT_W'(pop_p0);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_fire_p0 && !mispred_p0) begin
            pc_mem[wr_ptr]    <= push_pc;
            tgt_mem[wr_ptr]   <= push_pred_target;
            taken_mem[wr_ptr] <= push_pred_taken;
        end
    end

    // ---- p1: registered control, FSM and update outputs ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            pen_cnt     <= '0;
            busy        <= 1'b0;
            push_ready  <= 1'b1;
            q_empty     <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            upd_valid   <= 1'b0;
            flush       <= 1'b0;
            resolve_err <= 1'b0;
            upd_pc      <= '0;
            upd_target  <= '0;
            upd_taken   <= 1'b0;
            redirect_pc <= '0;
        end else begin
            wr_ptr      <= wr_n;
            rd_ptr      <= rd_n;
            count       <= count_n;
            q_empty     <= (count_n == '0);
            upd_valid   <= pop_p0;
            flush       <= mispred_p0;
            resolve_err <= err_p0;
            if (pop_p0) begin
                upd_pc     <= head_pc_p0;
                upd_taken  <= resolve_taken;
                upd_target <= upd_tgt_p0;
            end
            if (mispred_p0) redirect_pc <= correct_pc_p0;

            case (state)
                IDLE: begin
                    if (mispred_p0) begin
                        state      <= FLUSH;
                        pen_cnt    <= PEN_LOAD;
                        busy       <= 1'b1;
                        push_ready <= 1'b0;
                    end else begin
                        push_ready <= (count_n != FULL_CNT);
                    end
                end
                FLUSH: begin
                    if (pen_cnt == '0) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        push_ready <= (count_n != FULL_CNT);
                    end else begin
                        pen_cnt <= pen_cnt - PEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (pop_p0)     branch_cnt     <= sat_inc(branch_cnt);
            if (mispred_p0) mispredict_cnt <= sat_inc(mispredict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int DEPTH   = 4;
    localparam int PENALTY = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        q_empty;
    logic        resolve_err;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    always #5 CLK = ~CLK;

    branch_resolve_unit #(.DEPTH(DEPTH), .PENALTY(PENALTY)) dut (
        .CLK(CLK), .nRST(nRST),
        .push_valid(push_valid), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .push_ready(push_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .flush(flush), .redirect_pc(redirect_pc),
        .busy(busy), .q_empty(q_empty), .resolve_err(resolve_err)
`ifdef BRU_PERF_CNT_EN
        , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] red;
    } upd_t;

    ent_t        m_q[$];
    upd_t        sb[$];
    int          m_busy_left = 0;
    bit          m_flush = 1'b0;
    bit          m_err = 1'b0;
    int unsigned m_branch = 0;
    int unsigned m_mis = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    upd_t        mon_u;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_busy_left = 0;
        m_flush = 1'b0;
        m_err = 1'b0;
        m_branch = 0;
        m_mis = 0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the clock edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic rv, input logic rt,
                        input logic [31:0] rtgt);
        bit   bsy, acc, pop, err, mis;
        ent_t e;
        ent_t n;
        upd_t u;
        push_valid = pv; push_pc = pc; push_pred_taken = pt; push_pred_target = ptgt;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
        bsy = (m_busy_left > 0);
        acc = pv && !bsy && (m_q.size() != DEPTH);
        pop = rv && !bsy && (m_q.size() != 0);
        err = rv && !bsy && (m_q.size() == 0);
        mis = 1'b0;
        u = '{default: '0};
        if (pop) begin
            e = m_q[0];
            mis = (e.pt != rt) || (rt && e.tgt != rtgt);
            u.pc = e.pc;
            u.taken = rt;
            u.tgt = rt ? rtgt : e.tgt;
            u.red = rt ? rtgt : e.pc + 32'd4;
            u.mis = mis;
        end
        @(posedge CLK);
        if (pop) begin
            m_q.delete(0);
            sb.push_back(u);
            m_branch++;
            if (mis) m_mis++;
        end
        if (acc) begin
            n.pc = pc; n.pt = pt; n.tgt = ptgt;
            m_q.push_back(n);
        end
        if (bsy) m_busy_left--;
        if (mis) begin
            m_q.delete();
            m_busy_left = PENALTY;
        end
        m_flush = mis;
        m_err = err;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk1("push_ready", push_ready, (m_q.size() != DEPTH) && (m_busy_left == 0));
            chk1("busy", busy, m_busy_left > 0);
            chk1("q_empty", q_empty, m_q.size() == 0);
            chk1("resolve_err", resolve_err, m_err);
            chk1("flush", flush, m_flush);
`ifdef BRU_PERF_CNT_EN
            chk32("branch_cnt", branch_cnt, m_branch);
            chk32("mispredict_cnt", mispredict_cnt, m_mis);
`endif
            if (upd_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL upd_unexpected: got upd_valid=1 expected 0 at %0t", $time);
                end else begin
                    mon_u = sb.pop_front();
                    chk32("upd_pc", upd_pc, mon_u.pc);
                    chk1("upd_taken", upd_taken, mon_u.taken);
                    chk32("upd_target", upd_target, mon_u.tgt);
                    if (mon_u.mis) chk32("redirect_pc", redirect_pc, mon_u.red);
                end
            end else if (sb.size() != 0) begin
                n_cmp++; n_fail++;
                $display("FAIL upd_missing: got upd_valid=0 expected 1 at %0t", $time);
                sb.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        pv, pt, rv, rt;
        logic [31:0] pc, ptgt, rtgt;
        nRST = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        #1 nRST = 1'b0;
        #2;
        chk1("rst_push_ready", push_ready, 1'b1);
        chk1("rst_q_empty", q_empty, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_upd_valid", upd_valid, 1'b0);
        chk1("rst_resolve_err", resolve_err, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk32("rst_upd_pc", upd_pc, 32'h0);
        chk32("rst_upd_target", upd_target, 32'h0);
        chk1("rst_upd_taken", upd_taken, 1'b0);
        repeat (2) @(negedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
        mon_en = 1'b1;

        // correctly predicted not-taken branch
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(2);
        // taken with wrong target
        step(1'b1, 32'h200, 1'b1, 32'h240, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h280);
        step(1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(3);
        // predicted taken, actually not taken; same-cycle push is squashed
        step(1'b1, 32'h300, 1'b1, 32'h340, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(3);
        // fill, overflow push, push+pop while full, drain, then an empty resolve
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, 32'h1000 + 32'(i * 16), 1'b0, 32'h2000 + 32'(i), 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h9990, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(1);
        // wrap of pc+4 at the top of the address space, resolve during busy ignored
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h60, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(2);
        // reset in the middle of a penalty window
        step(1'b1, 32'h500, 1'b1, 32'h540, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge CLK);
        #1 mon_en = 1'b0;
        chk1("pre_rst_busy", busy, 1'b1);
        nRST = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_flush", flush, 1'b0);
        chk1("midrst_upd_valid", upd_valid, 1'b0);
        chk1("midrst_q_empty", q_empty, 1'b1);
        chk1("midrst_push_ready", push_ready, 1'b1);
`ifdef BRU_PERF_CNT_EN
        chk32("midrst_branch_cnt", branch_cnt, 32'h0);
        chk32("midrst_mispredict_cnt", mispredict_cnt, 32'h0);
`endif
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            pv   = ($urandom_range(0, 9) < 6);
            pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            pt   = 1'($urandom_range(0, 1));
            ptgt = $urandom() & 32'hFFFF_FFFC;
            rv   = ($urandom_range(0, 9) < 4);
            rt   = 1'($urandom_range(0, 1));
            rtgt = $urandom() & 32'hFFFF_FFFC;
            if (m_q.size() != 0) begin
                if ($urandom_range(0, 3) != 0) rt = m_q[0].pt;
                if ($urandom_range(0, 2) != 0) rtgt = m_q[0].tgt;
            end
            step(pv, pc, pt, ptgt, rv, rt, rtgt);
        end
        idle(PENALTY + 2);
        mon_en = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
